// File: rtl/ccip_rd_req_scheduler.sv
// ccip_rd_req_scheduler
//
// Round-robin scheduler that shares the CCI-P c0 read-request channel between
// NUM_INSTANCES requesters. It writes the source index into mdata[15:14] of each
// forwarded header. It limits the number of in-flight reads per requester and
// returns read-response credits to the requester named by the response tag. A
// drain handshake lets software quiesce all reads.
//
// Optional build macro:
//   PIPEARCH_SCHED_STATS_EN - adds per-instance grant counters and an almfull-stall
//                             counter, all 32-bit and saturating.
//
// Ports:
//   clk, reset_n  - clock; synchronous active-low reset
//   req_valid     - per-instance request present
//   req_hdr       - per-instance c0 request header (HDR_W bits, mdata in [15:0])
//   req_ready     - combinational one-hot grant (request consumed this cycle)
//   c0TxAlmFull   - channel almost-full; blocks all grants
//   tx_valid      - registered c0 request valid
//   tx_hdr        - registered c0 request header with mdata[15:14] = source
//   rsp_valid     - read response seen
//   rsp_tag       - mdata[15:14] of the read response
//   drain_req     - level; asks the scheduler to quiesce
//   drain_done    - level; no grants and zero reads outstanding
//   tag_err       - sticky; a response arrived for an instance with nothing in flight
//   stat_grants   - (stats build) per-instance grant counts
//   stat_stall    - (stats build) cycles in RUN with any request while almfull

module ccip_rd_req_scheduler #(
  parameter int unsigned NUM_INSTANCES   = 4,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned HDR_W           = 74
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_INSTANCES-1:0] req_valid,
  input  logic [HDR_W-1:0]         req_hdr [NUM_INSTANCES],
  output logic [NUM_INSTANCES-1:0] req_ready,
  input  logic                     c0TxAlmFull,
  output logic                     tx_valid,
  output logic [HDR_W-1:0]         tx_hdr,
  input  logic                     rsp_valid,
  input  logic [1:0]               rsp_tag,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     tag_err
`ifdef PIPEARCH_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_grants [NUM_INSTANCES],
  output logic [31:0]              stat_stall
`endif
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q [NUM_INSTANCES];
  logic [CNT_W-1:0]       cnt_d [NUM_INSTANCES];
  logic                   tx_valid_q, tx_valid_d;
  logic [HDR_W-1:0]       tx_hdr_q, tx_hdr_d;
  logic                   drain_done_q, drain_done_d;
  logic                   tag_err_q, tag_err_d;

  logic [NUM_INSTANCES-1:0] eligible;
  logic [NUM_INSTANCES-1:0] elig_rot;
  logic [NUM_INSTANCES-1:0] grant;
  logic                     any_grant;
  logic [1:0]               first_off;
  logic [2:0]               win_sum;
  logic [2:0]               nxt_sum;
  logic [1:0]               win_idx;
  logic                     all_zero_d;

  // Arbitration: rotate the eligible vector so ptr_q lands at bit 0, take the
  // lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      eligible[i] = (state_q == StRun) && !c0TxAlmFull && req_valid[i] &&
                    (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
    any_grant = |eligible;
    elig_rot  = NUM_INSTANCES'({eligible, eligible} >> ptr_q);

    first_off = '0;
    for (int j = NUM_INSTANCES - 1; j >= 0; j--) begin
      if (elig_rot[j]) first_off = 2'(j);
    end

    win_sum = {1'b0, ptr_q} + {1'b0, first_off};
    if (win_sum >= 3'(NUM_INSTANCES)) win_sum = win_sum - 3'(NUM_INSTANCES);
    win_idx = win_sum[1:0];

    nxt_sum = {1'b0, win_idx} + 3'd1;
    if (nxt_sum >= 3'(NUM_INSTANCES)) nxt_sum = nxt_sum - 3'(NUM_INSTANCES);
    ptr_d = any_grant ? nxt_sum[1:0] : ptr_q;

    for (int i = 0; i < NUM_INSTANCES; i++) begin
      grant[i] = any_grant && (win_idx == 2'(i));
    end
  end

  assign req_ready = grant;

  // Outstanding counters, response routing and the sticky tag error.
  always_comb begin
    logic rsp_hit;
    tag_err_d  = tag_err_q;
    all_zero_d = 1'b1;
    if (rsp_valid && ({1'b0, rsp_tag} >= 3'(NUM_INSTANCES))) tag_err_d = 1'b1;
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      rsp_hit  = rsp_valid && (rsp_tag == 2'(i));
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !rsp_hit) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!grant[i] && rsp_hit) begin
        // A response with nothing in flight is dropped rather than wrapping.
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        else                tag_err_d = 1'b1;
      end
      if (cnt_d[i] != '0) all_zero_d = 1'b0;
    end
  end

  // Drain FSM; DONE is judged on next-state counts so drain_done rises on the
  // edge that retires the last response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req) state_d = StDrain;
      StDrain: begin
        if (!drain_req)      state_d = StRun;
        else if (all_zero_d) state_d = StDone;
      end
      StDone:  if (!drain_req) state_d = StRun;
      default: state_d = StRun;
    endcase
    drain_done_d = (state_d == StDone);
  end

  // Registered c0 request.
  always_comb begin
    tx_valid_d = any_grant;
    tx_hdr_d   = '0;
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      if (grant[i]) begin
        tx_hdr_d        = req_hdr[i];
        tx_hdr_d[15:14] = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StRun;
      ptr_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_hdr_q     <= '0;
      drain_done_q <= 1'b0;
      tag_err_q    <= 1'b0;
      for (int i = 0; i < NUM_INSTANCES; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tx_valid_q   <= tx_valid_d;
      tx_hdr_q     <= tx_hdr_d;
      drain_done_q <= drain_done_d;
      tag_err_q    <= tag_err_d;
      for (int i = 0; i < NUM_INSTANCES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_hdr     = tx_hdr_q;
  assign drain_done = drain_done_q;
  assign tag_err    = tag_err_q;

`ifdef PIPEARCH_SCHED_STATS_EN
  logic [31:0] grants_q [NUM_INSTANCES];
  logic [31:0] grants_d [NUM_INSTANCES];
  logic [31:0] stall_q, stall_d;

  always_comb begin
    for (int i = 0; i < NUM_INSTANCES; i++) begin
      grants_d[i] = grants_q[i];
      if (grant[i] && (grants_q[i] != 32'hFFFF_FFFF)) grants_d[i] = grants_q[i] + 32'd1;
    end
    stall_d = stall_q;
    if ((state_q == StRun) && (|req_valid) && c0TxAlmFull && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      for (int i = 0; i < NUM_INSTANCES; i++) grants_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      for (int i = 0; i < NUM_INSTANCES; i++) grants_q[i] <= grants_d[i];
    end
  end

  assign stat_grants = grants_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_ccip_rd_req_scheduler.sv
// Directed bench for ccip_rd_req_scheduler (NUM_INSTANCES=4, MAX_OUTSTANDING=2).
// Expected c0 headers go into a scoreboard queue when a grant is expected and
// are popped and compared when tx_valid is due.

module tb_ccip_rd_req_scheduler;
  localparam int N    = 4;
  localparam int MAXO = 2;
  localparam int CW   = 8;
  localparam int HW   = 74;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  logic [HW-1:0] req_hdr [N];
  logic [N-1:0]  req_ready;
  logic          c0TxAlmFull;
  logic          tx_valid;
  logic [HW-1:0] tx_hdr;
  logic          rsp_valid;
  logic [1:0]    rsp_tag;
  logic          drain_req;
  logic          drain_done;
  logic          tag_err;
`ifdef PIPEARCH_SCHED_STATS_EN
  logic [31:0]   stat_grants [N];
  logic [31:0]   stat_stall;
`endif

  int            checks = 0;
  int            errors = 0;
  string         phase  = "init";
  logic [HW-1:0] sb [$];

  always #5 clk = ~clk;

  ccip_rd_req_scheduler #(
    .NUM_INSTANCES  (N),
    .MAX_OUTSTANDING(MAXO),
    .CNT_W          (CW),
    .HDR_W          (HW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_hdr    (req_hdr),
    .req_ready  (req_ready),
    .c0TxAlmFull(c0TxAlmFull),
    .tx_valid   (tx_valid),
    .tx_hdr     (tx_hdr),
    .rsp_valid  (rsp_valid),
    .rsp_tag    (rsp_tag),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .tag_err    (tag_err)
`ifdef PIPEARCH_SCHED_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall)
`endif
  );

  // Source headers carry mdata[15:14]=2'b11 so the tag overwrite is visible.
  function automatic logic [HW-1:0] base_hdr(input int i);
    return {26'h0, 32'hDEAD_0000 + 32'(i), 16'hFFF0 + 16'(i)};
  endfunction

  function automatic logic [HW-1:0] exp_hdr(input int i);
    logic [HW-1:0] h;
    h        = base_hdr(i);
    h[15:14] = 2'(i);
    return h;
  endfunction

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // One clock: optional response this cycle, expected winner w (-1 = none).
  // Entered and left at posedge+1.
  task automatic step(input int w, input logic rv = 1'b0, input logic [1:0] rt = 2'd0);
    logic [N-1:0]  er;
    logic [HW-1:0] e;
    rsp_valid = rv;
    rsp_tag   = rt;
    @(negedge clk);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", HW'(req_ready), HW'(er));
    if (w >= 0) sb.push_back(exp_hdr(w));
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    rsp_tag   = 2'd0;
    if (w >= 0) begin
      chk("tx_valid", HW'(tx_valid), HW'(1));
      e = sb.pop_front();
      chk("tx_hdr", tx_hdr, e);
    end else begin
      chk("tx_idle_valid", HW'(tx_valid), HW'(0));
      chk("tx_idle_hdr", tx_hdr, HW'(0));
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = '0;
    c0TxAlmFull = 1'b0;
    rsp_valid   = 1'b0;
    rsp_tag     = 2'd0;
    drain_req   = 1'b0;
    for (int i = 0; i < N; i++) req_hdr[i] = base_hdr(i);
    repeat (2) @(posedge clk);
    #1;

    phase = "reset";
    chk("tx_valid", HW'(tx_valid), HW'(0));
    chk("tx_hdr", tx_hdr, HW'(0));
    chk("drain_done", HW'(drain_done), HW'(0));
    chk("tag_err", HW'(tag_err), HW'(0));
    reset_n = 1'b1;

    // Fairness; later cycles return a response for the instance being granted.
    phase     = "rr";
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) step(c % 4, logic'(c >= 4), 2'(c % 4));
    req_valid = '0;
    for (int t = 0; t < 4; t++) step(-1, 1'b1, 2'(t));
    chk("tag_err", HW'(tag_err), HW'(0));

    // Outstanding limit on instance 1.
    phase     = "limit";
    req_valid = 4'b0010;
    step(1);
    step(1);
    step(-1);
    step(-1, 1'b1, 2'd1);
    step(1);
    step(-1);
    req_valid = 4'b0011;
    step(0);
    req_valid = '0;
    step(-1, 1'b1, 2'd0);
    step(-1, 1'b1, 2'd1);
    step(-1, 1'b1, 2'd1);

    // Almost-full blocks everyone; pointer holds.
    phase     = "almfull";
    req_valid = 4'hF;
    step(1);
    c0TxAlmFull = 1'b1;
    repeat (5) step(-1);
    c0TxAlmFull = 1'b0;
    step(2);
    step(3);
    req_valid = '0;
    for (int t = 1; t < 4; t++) step(-1, 1'b1, 2'(t));

    // Drain handshake.
    phase     = "drain";
    req_valid = 4'b0100;
    step(2);
    step(2);
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0110;
    drain_req = 1'b1;
    step(1);
    chk("drain_done_a", HW'(drain_done), HW'(0));
    step(-1);
    step(-1, 1'b1, 2'd2);
    step(-1, 1'b1, 2'd2);
    step(-1, 1'b1, 2'd1);
    chk("drain_done_b", HW'(drain_done), HW'(0));
    step(-1, 1'b1, 2'd1);
    chk("drain_done_c", HW'(drain_done), HW'(1));
    step(-1);
    chk("drain_done_d", HW'(drain_done), HW'(1));
    drain_req = 1'b0;
    step(-1);
    chk("drain_done_e", HW'(drain_done), HW'(0));
    step(2);
    req_valid = '0;
    drain_req = 1'b1;
    step(-1);
    drain_req = 1'b0;
    req_valid = 4'b1000;
    step(-1);
    step(3);
    req_valid = '0;
    chk("drain_done_f", HW'(drain_done), HW'(0));
    step(-1, 1'b1, 2'd2);
    step(-1, 1'b1, 2'd3);

    // Simultaneous grant and response, then an orphan response.
    phase     = "simul";
    req_valid = 4'b0001;
    step(0);
    step(0, 1'b1, 2'd0);
    step(0);
    step(-1);
    req_valid = '0;
    step(-1, 1'b1, 2'd0);
    step(-1, 1'b1, 2'd0);
    chk("tag_err_clear", HW'(tag_err), HW'(0));
    step(-1, 1'b1, 2'd3);
    chk("tag_err_set", HW'(tag_err), HW'(1));
    step(-1);
    step(-1);
    chk("tag_err_sticky", HW'(tag_err), HW'(1));

    // Reset with reads in flight.
    phase     = "midreset";
    req_valid = 4'hF;
    step(1);
    req_valid = '0;
    reset_n   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("tx_valid", HW'(tx_valid), HW'(0));
    chk("tx_hdr", tx_hdr, HW'(0));
    chk("drain_done", HW'(drain_done), HW'(0));
    chk("tag_err", HW'(tag_err), HW'(0));
    req_valid = 4'hF;
    step(0);
    req_valid = '0;
    step(-1, 1'b1, 2'd1);
    chk("tag_err_after", HW'(tag_err), HW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
